// File: rtl/bw_box3x3.sv
// bw_box3x3: streaming 3x3 box blur on the 4-bit grey nibble, two line buffers, latency 2.
module bw_box3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int X_W        = $clog2(IMG_WIDTH),
  parameter int Y_W        = $clog2(IMG_HEIGHT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [11:0]    pix_in,
  input  logic           pix_valid,
  input  logic           sof,
  output logic           out_valid,
  output logic [7:0]     sum_out,
  output logic [11:0]    bw_out,
  output logic [X_W-1:0] out_x,
  output logic [Y_W-1:0] out_y
);
  logic [X_W-1:0] x_q, cx, nx, cx1_q;
  logic [Y_W-1:0] y_q, cy, ny, cy1_q;
  logic           last_x, v1_q;
  logic [3:0]     lb1 [IMG_WIDTH];
  logic [3:0]     lb2 [IMG_WIDTH];
  logic [3:0]     win_q [3][3];
  logic [7:0]     sum_d;
  logic [13:0]    prod;
  logic           unused_ok;
  always_comb begin
    cx = sof ? '0 : x_q;
    cy = sof ? '0 : y_q;
    last_x = cx == X_W'(IMG_WIDTH - 1);
    nx = last_x ? '0 : cx + X_W'(1);
    ny = !last_x ? cy : (cy == Y_W'(IMG_HEIGHT - 1) ? '0 : cy + Y_W'(1));
    sum_d = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        sum_d = sum_d + 8'(win_q[r][c]);
    prod = {6'd0, sum_d} * 14'd57;
  end
  assign unused_ok = ^{pix_in[11:4], prod[13], prod[8:0]};
  // row y-1 moves down to row y-2 as the new pixel takes its place
  always_ff @(posedge clk)
    if (pix_valid) begin
      lb1[cx] <= pix_in[3:0];
      lb2[cx] <= lb1[cx];
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      v1_q <= 1'b0;
      cx1_q <= '0;
      cy1_q <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
      out_valid <= 1'b0;
      sum_out <= '0;
      bw_out <= '0;
      out_x <= '0;
      out_y <= '0;
    end else begin
      out_valid <= v1_q;
      v1_q <= pix_valid && cx >= X_W'(2) && cy >= Y_W'(2);
      if (pix_valid) begin
        x_q <= nx;
        y_q <= ny;
        cx1_q <= cx - X_W'(1);
        cy1_q <= cy - Y_W'(1);
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 2; c++)
            win_q[r][c] <= win_q[r][c+1];
        win_q[0][2] <= lb2[cx];
        win_q[1][2] <= lb1[cx];
        win_q[2][2] <= pix_in[3:0];
      end
      if (v1_q) begin
        sum_out <= sum_d;
        bw_out <= {3{prod[12:9]}};
        out_x <= cx1_q;
        out_y <= cy1_q;
      end
    end
  end
endmodule

// File: tb/tb_bw_box3x3.sv
// tb_bw_box3x3: scoreboard bench, frame-image reference model with randomized pixels and gaps.
module tb_bw_box3x3;
  localparam int W = 4;
  localparam int H = 4;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [11:0]   pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          sof = 1'b0;
  logic          out_valid;
  logic [7:0]    sum_out;
  logic [11:0]   bw_out;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;

  bw_box3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .out_valid(out_valid), .sum_out(sum_out), .bw_out(bw_out), .out_x(out_x), .out_y(out_y)
  );

  always #5 clk = ~clk;

  typedef struct {int sum; int bw; int x; int y; int due;} exp_t;
  exp_t q[$];
  int   img [H][W];
  int   mx = 0, my = 0;
  int   cyc = 0, pulses = 0;
  int   compared = 0, mismatched = 0;
  int   last_sum = 0, last_bw = 0, last_x = 0, last_y = 0;
  logic rst_seen = 1'b0;

  always @(posedge clk) begin
    cyc++;
    rst_seen <= rst;
  end

  task automatic chk(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: store the pixel into the frame image and blur the 3x3 block ending at it.
  task automatic model_accept(input int p, input bit s);
    exp_t e;
    if (s) begin mx = 0; my = 0; end
    img[my][mx] = p;
    if (mx >= 2 && my >= 2) begin
      e.sum = 0;
      for (int r = my - 2; r <= my; r++)
        for (int c = mx - 2; c <= mx; c++)
          e.sum += img[r][c];
      e.bw = ((e.sum * 57) >> 9) * 'h111;
      e.x = mx - 1;
      e.y = my - 1;
      e.due = cyc + 2;
      q.push_back(e);
    end
    mx++;
    if (mx == W) begin mx = 0; my = (my + 1) % H; end
  endtask

  task automatic drive(input bit v, input int p, input bit s, input bit r);
    @(posedge clk);
    #1;
    rst = r;
    pix_valid = v;
    sof = s;
    pix_in = {3{4'(p)}};
    if (r) begin
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      mx = 0;
      my = 0;
    end else if (v) model_accept(p, s);
  endtask

  // mode 0: constant cval, 1: impulse 9 at (1,1), 2: random
  task automatic run_frame(input int mode, input int cval, input bit gaps, input bit first_sof, input int npix);
    int p;
    for (int i = 0; i < npix; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) drive(0, 0, 0, 0);
      p = mode == 0 ? cval : mode == 1 ? ((i == W + 1) ? 9 : 0) : int'($urandom_range(0, 15));
      drive(1, p, first_sof && i == 0, 0);
    end
  endtask

  task automatic settle_and_count(input string name, input int base, input int want);
    repeat (5) drive(0, 0, 0, 0);
    chk(name, pulses - base, want);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_sum", int'(sum_out), 0);
      chk("rst_bw", int'(bw_out), 0);
      chk("rst_xy", int'({out_x, out_y}), 0);
      last_sum = 0; last_bw = 0; last_x = 0; last_y = 0;
    end else if (out_valid) begin
      pulses++;
      if (q.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        e = q.pop_front();
        chk("sum_out", int'(sum_out), e.sum);
        chk("bw_out", int'(bw_out), e.bw);
        chk("out_x", int'(out_x), e.x);
        chk("out_y", int'(out_y), e.y);
        chk("latency_cycle", cyc, e.due);
        last_sum = e.sum; last_bw = e.bw; last_x = e.x; last_y = e.y;
      end
    end else begin
      chk("hold_sum", int'(sum_out), last_sum);
      chk("hold_bw", int'(bw_out), last_bw);
      if (q.size() > 0 && q[0].due < cyc) begin
        chk("missing_pulse_due", cyc, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int base;
    repeat (3) drive(0, 0, 0, 1);
    base = pulses;
    drive(1, 5, 1, 0);
    settle_and_count("single_pixel_pulses", base, 0);
    base = pulses;
    run_frame(0, 5, 0, 1, W * H);
    settle_and_count("const5_pulses", base, 4);
    base = pulses;
    run_frame(1, 0, 0, 1, W * H);
    settle_and_count("impulse_pulses", base, 4);
    for (int k = 0; k < 3; k++) begin
      base = pulses;
      run_frame(0, 15, 1, 1, W * H);
      settle_and_count("const15_gaps_pulses", base, 4);
    end
    for (int k = 0; k < 6; k++) begin
      base = pulses;
      run_frame(2, 0, k[0], 1, W * H);
      settle_and_count("random_pulses", base, 4);
    end
    for (int k = 0; k < 3; k++) begin
      base = pulses;
      run_frame(2, 0, 0, 1, 7);
      run_frame(2, 0, k[0], 1, W * H);
      settle_and_count("midframe_sof_pulses", base, 4);
    end
    base = pulses;
    run_frame(2, 0, 0, 1, 2 * W + 3);
    drive(0, 0, 0, 1);
    run_frame(0, 5, 0, 0, W * H);
    settle_and_count("rst_after_qual_pulses", base, 4);
    repeat (4) drive(0, 0, 0, 0);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
